// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer: FSM state codes,
// the complex-word width helper and the bit-reversal function.
package fft_reorder_pkg;

  // Write-side states
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_FILL  = 2'd1;
  localparam logic [1:0] W_DROP  = 2'd2;

  // Read-side states
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  // Complex word is {re, im}, each nbits wide
  function automatic int cw_bits(input int nbits);
    return 2 * nbits;
  endfunction

  // Reverse the low nbits of idx; upper bits of the result are zero
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[i] = idx[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Two-bank x 2**AW-entry register file: two write ports sharing one enable
// and bank select, two read ports registered into the output word.
module fft_reorder_ram #(
  parameter int W  = 6,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr_a,
  input  logic [AW-1:0] waddr_b,
  input  logic [W-1:0]  wdata_a,
  input  logic [W-1:0]  wdata_b,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem [0:2*(2**AW)-1];

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbank, waddr_a}] <= wdata_a;
      mem[{wbank, waddr_b}] <= wdata_b;
    end
  end

  // Registered read; holds its value whenever re is low (sink stall)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[{rbank, raddr_a}];
      rdata_b <= mem[{rbank, raddr_b}];
    end
  end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer behind the two-lane FFT core: captures each
// bit-reversed frame into a free bank, replays it in natural bin order
// behind a valid/ready handshake. Frames with no free bank are dropped.
// Optional build macro FFT_REORDER_DROPCNT_EN adds the drop_cnt port.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for in_sof
//   W_FILL | storing beats 1..N/2-1 into wr_bank
//   W_DROP | discarding a frame that found no free bank
// Read FSM
//   state   | meaning
//   R_IDLE  | waiting for full[rd_bank]
//   R_DRAIN | presenting beats of rd_bank on the output
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int NBITS = 3,
  parameter int N     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [2*NBITS-1:0] in_up,
  input  logic [2*NBITS-1:0] in_down,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*NBITS-1:0] out_up,
  output logic [2*NBITS-1:0] out_down,
  output logic               out_sof,
  output logic               out_eof,
  output logic               ovf,
`ifdef FFT_REORDER_DROPCNT_EN
  output logic [7:0]         drop_cnt,
`endif
  output logic               sync_err
);

  localparam int W     = cw_bits(NBITS);
  localparam int LOG2N = $clog2(N);
  localparam int BW    = LOG2N - 1;
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N/2 - 1);

  logic [1:0]       wr_st;
  logic [0:0]       rd_st;
  logic [BW-1:0]    wcnt, dcnt, rcnt;
  logic             wr_bank, rd_bank;
  logic [1:0]       full;

  logic             sof_hit, rd_done, bank_free, fill_done, drop_event, we;
  logic [BW-1:0]    wbeat, rd_beat;
  logic [LOG2N-1:0] waddr_up, waddr_dn;
  logic             rd_load, rd_sel;

  assign sof_hit    = in_valid && in_sof;
  assign rd_done    = out_valid && out_ready && out_eof;
  // A bank released by the reader on this edge may be refilled on the same edge
  assign bank_free  = !full[wr_bank] || (rd_done && (rd_bank == wr_bank));
  assign fill_done  = (wr_st == W_FILL) && in_valid && !in_sof && (wcnt == LAST_BEAT);
  assign drop_event = sof_hit && (wr_st != W_FILL) && !bank_free;
  assign we         = in_valid && ((wr_st == W_FILL) || (in_sof && bank_free));

  // Write address: beat c lanes carry bins bitrev(2c), bitrev(2c+1); store by bin
  always_comb begin
    wbeat    = (wr_st == W_FILL && !in_sof) ? wcnt : '0;
    waddr_up = LOG2N'(bitrev(32'({wbeat, 1'b0}), LOG2N));
    waddr_dn = LOG2N'(bitrev(32'({wbeat, 1'b1}), LOG2N));
  end

  // Write FSM, overflow flag and sync error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_st    <= W_IDLE;
      wcnt     <= '0;
      dcnt     <= '0;
      wr_bank  <= 1'b0;
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (drop_event) ovf <= 1'b1;
      case (wr_st)
        W_FILL: begin
          if (in_valid) begin
            if (in_sof) begin
              sync_err <= 1'b1;
              wcnt     <= BEAT_ONE;
            end else if (wcnt == LAST_BEAT) begin
              wr_bank <= ~wr_bank;
              wcnt    <= '0;
              wr_st   <= W_IDLE;
            end else begin
              wcnt <= wcnt + BEAT_ONE;
            end
          end
        end
        default: begin
          // W_IDLE and W_DROP both honour a new in_sof immediately
          if (sof_hit) begin
            if (bank_free) begin
              wcnt  <= BEAT_ONE;
              wr_st <= W_FILL;
            end else begin
              dcnt  <= BEAT_ONE;
              wr_st <= W_DROP;
            end
          end else if (wr_st == W_DROP && in_valid) begin
            if (dcnt == LAST_BEAT) wr_st <= W_IDLE;
            else                   dcnt  <= dcnt + BEAT_ONE;
          end
        end
      endcase
    end
  end

`ifdef FFT_REORDER_DROPCNT_EN
  // Saturating count of dropped frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               drop_cnt <= 8'd0;
    else if (drop_event && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

  // Bank occupancy: writer sets on frame completion, reader clears after eof
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      if (rd_done)   full[rd_bank] <= 1'b0;
      if (fill_done) full[wr_bank] <= 1'b1;
    end
  end

  // Which beat (and bank) to load into the output register this cycle
  always_comb begin
    rd_load = 1'b0;
    rd_sel  = rd_bank;
    rd_beat = rcnt;
    if (rd_st == R_DRAIN) begin
      if (!out_valid) begin
        rd_load = 1'b1;
      end else if (out_ready) begin
        if (!out_eof) begin
          rd_load = 1'b1;
          rd_beat = rcnt + BEAT_ONE;
        end else if (full[~rd_bank]) begin
          rd_load = 1'b1;
          rd_sel  = ~rd_bank;
          rd_beat = '0;
        end
      end
    end
  end

  // Read FSM and output qualifiers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_st     <= R_IDLE;
      rcnt      <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (rd_st == R_IDLE) begin
      if (full[rd_bank]) begin
        rd_st <= R_DRAIN;
        rcnt  <= '0;
      end
    end else begin
      if (rd_load) begin
        rcnt      <= rd_beat;
        out_valid <= 1'b1;
        out_sof   <= (rd_beat == '0);
        out_eof   <= (rd_beat == LAST_BEAT);
      end
      if (rd_done) begin
        rd_bank <= ~rd_bank;
        if (!rd_load) begin
          rd_st     <= R_IDLE;
          out_valid <= 1'b0;
          out_sof   <= 1'b0;
          out_eof   <= 1'b0;
        end
      end
    end
  end

  fft_reorder_ram #(.W(W), .AW(LOG2N)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wbank   (wr_bank),
    .waddr_a (waddr_up),
    .waddr_b (waddr_dn),
    .wdata_a (in_up),
    .wdata_b (in_down),
    .re      (rd_load),
    .rbank   (rd_sel),
    .raddr_a ({rd_beat, 1'b0}),
    .raddr_b ({rd_beat, 1'b1}),
    .rdata_a (out_up),
    .rdata_b (out_down)
  );

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder (N=16, NBITS=3). Expected output beats are
// built from a bin-to-word model and checked by a handshake monitor.
module tb_fft_reorder;

  localparam int NBITS = 3;
  localparam int N     = 16;

  typedef struct packed {
    logic [5:0] up;
    logic [5:0] dn;
    logic       sof;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [5:0] in_up = '0;
  logic [5:0] in_down = '0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_sof, out_eof, ovf, sync_err;
  logic [5:0] out_up, out_down;
`ifdef FFT_REORDER_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  int    wn, bubbles, k;
  bit    sent;

  always #5 clk = ~clk;

  fft_reorder #(.NBITS(NBITS), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_up     (in_up),
    .in_down   (in_down),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_up    (out_up),
    .out_down  (out_down),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .ovf       (ovf),
`ifdef FFT_REORDER_DROPCNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .sync_err  (sync_err)
  );

  function automatic logic [5:0] word(input int b, input int seed);
    return 6'((b * 5 + seed) & 63);
  endfunction

  function automatic int brev4(input int x);
    logic [3:0] v;
    v = 4'(x);
    return int'({v[0], v[1], v[2], v[3]});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input int seed);
    beat_t b;
    for (int c = 0; c < N/2; c++) begin
      b.up  = word(2*c, seed);
      b.dn  = word(2*c+1, seed);
      b.sof = (c == 0);
      b.eof = (c == N/2-1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input int c, input int seed, input bit sof);
    in_valid = 1'b1;
    in_sof   = sof;
    in_up    = word(brev4(2*c), seed);
    in_down  = word(brev4(2*c+1), seed);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int seed, input bit gaps);
    for (int c = 0; c < N/2; c++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send_beat(c, seed, c == 0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
    @(negedge clk); @(negedge clk);
    check("idle_after_drain", 32'(out_valid), 0);
  endtask

  // Scoreboard: every accepted output beat must match the head of exp_q
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_up",  32'(out_up),   32'(mon_e.up));
        check("out_down", 32'(out_down), 32'(mon_e.dn));
        check("out_sof", 32'(out_sof),  32'(mon_e.sof));
        check("out_eof", 32'(out_eof),  32'(mon_e.eof));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_ovf",       32'(ovf),       0);
    check("rst_sync_err",  32'(sync_err),  0);
    check("rst_out_up",    32'(out_up),    0);
    check("rst_sof_eof",   32'({out_sof, out_eof}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single frame, latency from last input beat
    out_ready = 1'b1;
    expect_frame(0);
    send_frame(0, 1'b0);
    @(negedge clk); check("lat_e0", 32'(out_valid), 0);
    @(negedge clk); check("lat_e1", 32'(out_valid), 0);
    @(negedge clk); check("lat_e2", 32'(out_valid), 1);
    check("lat_first_sof", 32'(out_sof), 1);
    check("lat_first_up",  32'(out_up), 32'(word(0, 0)));
    wait_drain();

    // 2: back-to-back frames, no bubble
    expect_frame(10);
    expect_frame(20);
    fork
      begin
        send_frame(10, 1'b0);
        send_frame(20, 1'b0);
      end
      begin
        wn = 0;
        while (!out_valid && wn < 100) begin @(negedge clk); wn++; end
        bubbles = 0;
        for (int i = 0; i < N; i++) begin
          if (!out_valid) bubbles++;
          @(negedge clk);
        end
      end
    join
    check("b2b_bubbles", 32'(bubbles), 0);
    wait_drain();
    check("b2b_ovf", 32'(ovf), 0);

    // 3: sink stalled while three frames arrive; third is dropped
    out_ready = 1'b0;
    expect_frame(30);
    expect_frame(40);
    send_frame(30, 1'b0);
    send_frame(40, 1'b0);
    send_frame(50, 1'b0);
    @(negedge clk);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_ovf",   32'(ovf), 1);
`ifdef FFT_REORDER_DROPCNT_EN
    check("stall_drop_cnt", 32'(drop_cnt), 1);
`endif
    repeat (10) @(negedge clk);
    check("stall_hold_valid", 32'(out_valid), 1);
    check("stall_hold_up",    32'(out_up),   32'(word(0, 30)));
    check("stall_hold_down",  32'(out_down), 32'(word(1, 30)));
    check("stall_hold_sof",   32'(out_sof), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    check("ovf_sticky", 32'(ovf), 1);

    // 4: in_sof at beat 5 restarts the frame
    expect_frame(7);
    for (int c = 0; c < 5; c++) send_beat(c, 3, c == 0);
    send_beat(0, 7, 1'b1);
    @(negedge clk); check("sync_err_pulse", 32'(sync_err), 1);
    send_beat(1, 7, 1'b0);
    @(negedge clk); check("sync_err_clear", 32'(sync_err), 0);
    for (int c = 2; c < N/2; c++) send_beat(c, 7, 1'b0);
    wait_drain();

    // 5: random input gaps and random sink readiness
    expect_frame(60);
    expect_frame(70);
    sent = 1'b0;
    fork
      begin
        send_frame(60, 1'b1);
        send_frame(70, 1'b1);
        sent = 1'b1;
      end
      begin
        k = 0;
        while (!sent && k < 300) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          k++;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // 6: asynchronous reset in the middle of a drain
    expect_frame(90);
    send_frame(90, 1'b0);
    wn = 0;
    while (!out_valid && wn < 50) begin @(negedge clk); wn++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_ovf",   32'(ovf), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    expect_frame(100);
    send_frame(100, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
